uart_loader: RTL and testbench
==============================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 12_000_000, maximum idle clocks between frame bytes.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  byte-ready level from the UART receiver; may stay high for many clocks.
REQ-007 SHALL have port mem_addr  output  16  memory write address.
REQ-008 SHALL have port mem_wdata  output  8  memory write data.
REQ-009 SHALL have port mem_req  output  1  write request, held until acknowledged.
REQ-010 SHALL have port mem_ack  input  1  memory write acknowledge.
REQ-011 SHALL have port cpu_rst  output  1  CPU reset hold, active-high.
REQ-012 SHALL have port run_addr  output  16  CPU start address, valid while cpu_rst low.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port frame_ok  output  1  one-clock pulse, frame accepted.
REQ-015 SHALL have port frame_err  output  1  one-clock pulse, frame rejected.
REQ-016 SHALL have port err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-017 SHALL accept a byte only on a rising edge of rx_valid (registered edge detect); one byte per edge, regardless of high-level duration.
REQ-018 SHALL parse the frame 0xA5, CMD, ADDR_H, ADDR_L, LEN, payload, CHK; states IDLE, CMD, ADDR_H, ADDR_L, LEN, DATA, CHK.
REQ-019 SHALL, in IDLE, discard every byte except 0xA5, which moves to CMD.
REQ-020 SHALL support CMD 0x01 WRITE, 0x02 RUN, 0x03 HALT; any other CMD pulses frame_err and returns to IDLE on the same accepted-byte clock.
REQ-021 SHALL, for WRITE, interpret LEN 0 as 256 payload bytes, LEN 1..255 literally; for RUN/HALT, go from LEN directly to CHK, ignoring LEN.
REQ-022 SHALL, per WRITE payload byte, drive mem_addr = ADDR + index (mod 65536, wrapping 0xFFFF->0x0000) and mem_wdata = byte, and assert mem_req the clock after the accept.
REQ-023 SHALL hold mem_req, mem_addr, mem_wdata stable until a clock with mem_ack high, deasserting mem_req the following clock; mem_ack with mem_req low is ignored.
REQ-024 SHALL treat a new byte accepted while mem_req is pending as overrun: frame_err pulse, mem_req completes normally, parser returns to IDLE.
REQ-025 SHALL require the 8-bit sum of CMD, ADDR_H, ADDR_L, LEN, all payload bytes and CHK to equal 0x00 (mod 256); otherwise frame_err.
REQ-026 SHALL, on valid CHK: pulse frame_ok; RUN loads run_addr = {ADDR_H,ADDR_L} and clears cpu_rst the next clock; HALT sets cpu_rst; WRITE changes neither.
REQ-027 SHALL not roll back memory written by a WRITE frame whose checksum later fails.
REQ-028 SHALL, when busy and no byte accepted for TIMEOUT_CYCLES consecutive clocks, pulse frame_err and return to IDLE; counter resets on every accepted byte.
REQ-029 SHALL increment err_cnt on every frame_err pulse, saturating at 0xFF.
REQ-030 SHALL never pulse frame_ok and frame_err in the same clock; each frame yields at most one pulse.

Reset
REQ-031 SHALL, while rst high, force IDLE, cpu_rst=1, run_addr=0x0000, mem_req=0, mem_addr=0x0000, mem_wdata=0x00, frame_ok=0, frame_err=0, err_cnt=0x00, busy=0, timeout counter 0, edge detector primed so a level-high rx_valid at reset release is not accepted.
REQ-032 SHALL, on rst mid-frame or mid-write, abandon the frame and drop mem_req the next clock without waiting for mem_ack.

Verification
REQ-033 SHALL pass: A5 01 10 00 02 3E 42 6D, mem_ack one clock after each mem_req -> writes 0x1000=0x3E, 0x1001=0x42, one frame_ok, cpu_rst stays 1.
REQ-034 SHALL pass: A5 02 10 00 00 EE -> frame_ok, run_addr=0x1000, cpu_rst 1->0; then A5 03 00 00 00 FD -> frame_ok, cpu_rst=1.
REQ-035 SHALL pass: A5 01 10 00 02 3E 42 6C -> both bytes written, frame_err, err_cnt=1.
REQ-036 SHALL pass: WRITE ADDR=0xFFFF LEN=2, valid CHK -> writes to 0xFFFF then 0x0000, frame_ok.
REQ-037 SHALL pass: rx_valid held high 100 clocks per byte -> each byte accepted once; frame stopped after A5 01 with TIMEOUT_CYCLES=1000 -> frame_err after 1000 idle clocks, busy=0.
REQ-038 SHALL pass: mem_ack withheld, next payload byte arrives -> frame_err, mem_req remains until ack, err_cnt increments; 300 errors -> err_cnt=0xFF.

Source files
------------

// File: rtl/uart_loader_if.sv
// Byte stream and memory-write bus between the UART loader and its neighbours.
// The loader uses the master view; the UART receiver and memory use the slave view.
interface uart_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_ack;

  modport master (
    input  rx_data, rx_valid, mem_ack,
    output mem_addr, mem_wdata, mem_req
  );

  modport slave (
    output rx_data, rx_valid, mem_ack,
    input  mem_addr, mem_wdata, mem_req
  );
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: parses A5-framed WRITE/RUN/HALT commands from a byte
// stream, writes payload to memory through a req/ack handshake, and controls
// the CPU reset and start address.
module uart_loader #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic          clk,
  input  logic          rst,
  uart_loader_if.master bus,
  output logic          cpu_rst,
  output logic [15:0]   run_addr,
  output logic          busy,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [7:0]    err_cnt
);

  // A non-positive timeout falls back to one second of idle clocks.
  localparam int          TO_LIMIT    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : CLK_FREQ;
  localparam logic [31:0] TO_LAST     = 32'(TO_LIMIT - 1);
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam logic [7:0]  CMD_WRITE   = 8'h01;
  localparam logic [7:0]  CMD_RUN     = 8'h02;
  localparam logic [7:0]  CMD_HALT    = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CHK
  } state_t;

  state_t      state_q;
  logic        rx_valid_q;
  logic [7:0]  cmd_q;
  logic [7:0]  addr_h_q;
  logic [15:0] base_addr_q;
  logic [15:0] wr_addr_q;
  logic [8:0]  remain_q;
  logic [7:0]  sum_q;
  logic [31:0] to_cnt_q;
  logic        mem_req_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        cpu_rst_q;
  logic [15:0] run_addr_q;
  logic        frame_ok_q;
  logic        frame_err_q;
  logic [7:0]  err_cnt_q;

  logic        rx_accept;
  logic [7:0]  sum_d;
  logic        overrun;

  // One byte per rising edge of the receiver's level-style valid.
  assign rx_accept = bus.rx_valid & ~rx_valid_q;
  assign sum_d     = sum_q + bus.rx_data;
  // A byte arriving mid-frame while the previous write is still unacknowledged.
  assign overrun   = (state_q != S_IDLE) & mem_req_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame parser, memory handshake, timeout and status outputs in one registered FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_valid_q  <= 1'b1;  // primed: a level already high at release is not an edge
      cmd_q       <= 8'h00;
      addr_h_q    <= 8'h00;
      base_addr_q <= 16'h0000;
      wr_addr_q   <= 16'h0000;
      remain_q    <= 9'd0;
      sum_q       <= 8'h00;
      to_cnt_q    <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      cpu_rst_q   <= 1'b1;
      run_addr_q  <= 16'h0000;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      rx_valid_q  <= bus.rx_valid;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // Write completes the clock after the acknowledge is seen.
      if (mem_req_q && bus.mem_ack) begin
        mem_req_q <= 1'b0;
      end

      if (rx_accept || state_q == S_IDLE) begin
        to_cnt_q <= 32'd0;
      end else begin
        to_cnt_q <= to_cnt_q + 32'd1;
      end

      if (rx_accept) begin
        if (overrun) begin
          frame_err_q <= 1'b1;
          err_cnt_q   <= sat_inc8(err_cnt_q);
          state_q     <= S_IDLE;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (bus.rx_data == SYNC_BYTE) begin
                state_q <= S_CMD;
              end
            end
            S_CMD: begin
              if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_RUN ||
                  bus.rx_data == CMD_HALT) begin
                cmd_q   <= bus.rx_data;
                sum_q   <= bus.rx_data;
                state_q <= S_ADDR_H;
              end else begin
                frame_err_q <= 1'b1;
                err_cnt_q   <= sat_inc8(err_cnt_q);
                state_q     <= S_IDLE;
              end
            end
            S_ADDR_H: begin
              addr_h_q <= bus.rx_data;
              sum_q    <= sum_d;
              state_q  <= S_ADDR_L;
            end
            S_ADDR_L: begin
              base_addr_q <= {addr_h_q, bus.rx_data};
              wr_addr_q   <= {addr_h_q, bus.rx_data};
              sum_q       <= sum_d;
              state_q     <= S_LEN;
            end
            S_LEN: begin
              sum_q <= sum_d;
              // LEN of zero means a full 256-byte block.
              remain_q <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
              state_q  <= (cmd_q == CMD_WRITE) ? S_DATA : S_CHK;
            end
            S_DATA: begin
              sum_q       <= sum_d;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= wr_addr_q;
              mem_wdata_q <= bus.rx_data;
              wr_addr_q   <= wr_addr_q + 16'd1;
              remain_q    <= remain_q - 9'd1;
              state_q     <= (remain_q == 9'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
              state_q <= S_IDLE;
              if (sum_d == 8'h00) begin
                frame_ok_q <= 1'b1;
                if (cmd_q == CMD_RUN) begin
                  run_addr_q <= base_addr_q;
                  cpu_rst_q  <= 1'b0;
                end else if (cmd_q == CMD_HALT) begin
                  cpu_rst_q  <= 1'b1;
                end else begin
                  cpu_rst_q  <= cpu_rst_q;
                end
              end else begin
                frame_err_q <= 1'b1;
                err_cnt_q   <= sat_inc8(err_cnt_q);
              end
            end
            default: begin
              state_q <= S_IDLE;
            end
          endcase
        end
      end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
        frame_err_q <= 1'b1;
        err_cnt_q   <= sat_inc8(err_cnt_q);
        state_q     <= S_IDLE;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign run_addr      = run_addr_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_ok      = frame_ok_q;
  assign frame_err     = frame_err_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rst;
  logic [15:0] run_addr;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_cnt;

  uart_loader_if bus ();

  uart_loader #(.CLK_FREQ(12_000_000), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cpu_rst(cpu_rst), .run_addr(run_addr),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ok_seen  = 0;
  int err_seen = 0;
  logic ack_en = 1'b1;

  logic [7:0]  frm[$];
  logic [23:0] got_wr[$];
  logic [23:0] exp_wr[$];
  int          exp_ok, exp_err;
  logic        exp_cpu_rst;
  logic [15:0] exp_run_addr;
  logic [7:0]  exp_err_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory responder: acknowledge each request one clock after it appears.
  always @(negedge clk) begin
    if (bus.mem_ack) bus.mem_ack = 1'b0;
    else if (bus.mem_req && ack_en) begin
      got_wr.push_back({bus.mem_addr, bus.mem_wdata});
      bus.mem_ack = 1'b1;
    end
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok) ok_seen++;
      if (frame_err) err_seen++;
      if (frame_ok || frame_err) check_eq("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Frame-level reference: what a frame in frm should do to memory and status.
  task automatic model_frame();
    logic [7:0]  cmd, s;
    logic [15:0] base;
    int          n;
    exp_wr.delete();
    exp_ok = 0;
    exp_err = 0;
    cmd = frm[1];
    if (cmd < 8'd1 || cmd > 8'd3) exp_err = 1;
    else begin
      base = {frm[2], frm[3]};
      n = (cmd != 8'd1) ? 0 : (frm[4] == 8'd0) ? 256 : int'(frm[4]);
      for (int i = 0; i < n; i++) exp_wr.push_back({16'(base + 16'(i)), frm[5 + i]});
      s = 8'd0;
      for (int i = 1; i < frm.size(); i++) s = s + frm[i];
      if (s == 8'd0) begin
        exp_ok = 1;
        if (cmd == 8'd2) begin exp_run_addr = base; exp_cpu_rst = 1'b0; end
        if (cmd == 8'd3) exp_cpu_rst = 1'b1;
      end else exp_err = 1;
    end
    if (exp_err != 0) exp_err_cnt = sat8(exp_err_cnt);
  endtask

  task automatic run_frame(input string tag, input int hold);
    int ok0, err0, m;
    got_wr.delete();
    ok0 = ok_seen;
    err0 = err_seen;
    model_frame();
    foreach (frm[i]) send_byte(frm[i], hold);
    repeat (6) @(negedge clk);
    check_eq({tag, ":ok_pulses"}, 32'(ok_seen - ok0), 32'(exp_ok));
    check_eq({tag, ":err_pulses"}, 32'(err_seen - err0), 32'(exp_err));
    check_eq({tag, ":wr_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    m = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++) check_eq({tag, ":wr_item"}, 32'(got_wr[i]), 32'(exp_wr[i]));
    check_eq({tag, ":cpu_rst"}, 32'(cpu_rst), 32'(exp_cpu_rst));
    check_eq({tag, ":run_addr"}, 32'(run_addr), 32'(exp_run_addr));
    check_eq({tag, ":err_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
    check_eq({tag, ":busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] cmd, len, s, chk;
    logic [15:0] a;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    exp_cpu_rst  = 1'b1;
    exp_run_addr = 16'h0000;
    exp_err_cnt  = 8'h00;
    repeat (4) @(negedge clk);
    check_eq("rst:cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst:run_addr", 32'(run_addr), 32'd0);
    check_eq("rst:mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst:mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst:mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check_eq("rst:pulses", 32'({frame_ok, frame_err}), 32'd0);
    check_eq("rst:err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst:busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    frm = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h02, 8'h3E, 8'h42, 8'h6D};
    run_frame("write2", 1);
    check_eq("write2:first", 32'(got_wr.size() > 0 ? got_wr[0] : 24'h0), 32'h10003E);
    run_frame("write2_hold100", 100);
    frm = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'hEE};
    run_frame("run", 1);
    check_eq("run:run_addr_const", 32'(run_addr), 32'h1000);
    frm = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFD};
    run_frame("halt", 2);
    frm = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h02, 8'h3E, 8'h42, 8'h6C};
    run_frame("badchk", 1);
    check_eq("badchk:err_cnt_const", 32'(err_cnt), 32'd1);
    frm = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCC};
    run_frame("wrap", 1);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(0, 9);
      cmd = (n < 6) ? 8'h01 : (n < 8) ? 8'h02 : (n == 8) ? 8'h03 : 8'(4 + $urandom_range(0, 250));
      frm.delete();
      frm.push_back(8'hA5);
      frm.push_back(cmd);
      if (cmd <= 8'h03) begin
        a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
        len = (cmd != 8'h01) ? 8'($urandom) : (f == 5) ? 8'h00 : 8'($urandom_range(1, 6));
        frm.push_back(a[15:8]);
        frm.push_back(a[7:0]);
        frm.push_back(len);
        if (cmd == 8'h01) begin
          n = (len == 8'h00) ? 256 : int'(len);
          for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
        end
        s = 8'h00;
        for (int i = 1; i < frm.size(); i++) s = s + frm[i];
        chk = 8'h00 - s;
        if ($urandom_range(0, 3) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
        frm.push_back(chk);
      end
      run_frame("rand", $urandom_range(1, 3));
    end

    // Overrun: second payload byte arrives while the first write is unacknowledged.
    ack_en = 1'b0;
    got_wr.delete();
    n = err_seen;
    frm = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22};
    foreach (frm[i]) send_byte(frm[i], 1);
    repeat (3) @(negedge clk);
    exp_err_cnt = sat8(exp_err_cnt);
    check_eq("ovr:err_pulses", 32'(err_seen - n), 32'd1);
    check_eq("ovr:mem_req_held", 32'(bus.mem_req), 32'd1);
    check_eq("ovr:mem_addr_held", 32'(bus.mem_addr), 32'h2000);
    check_eq("ovr:mem_wdata_held", 32'(bus.mem_wdata), 32'h11);
    check_eq("ovr:busy", 32'(busy), 32'd0);
    check_eq("ovr:err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("ovr:wr_count", 32'(got_wr.size()), 32'd1);
    check_eq("ovr:wr_item", 32'(got_wr.size() > 0 ? got_wr[0] : 24'h0), 32'h200011);
    check_eq("ovr:mem_req_done", 32'(bus.mem_req), 32'd0);

    // Timeout after A5 01 with 100-clock valid levels.
    send_byte(8'hA5, 100);
    @(negedge clk);
    bus.rx_data  = 8'h01;
    bus.rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 100) bus.rx_valid = 1'b0;
      if (n == 500) check_eq("to:busy_mid", 32'(busy), 32'd1);
    end while (!frame_err && n < 1100);
    exp_err_cnt = sat8(exp_err_cnt);
    check_eq("to:idle_clocks", 32'(n - 1), 32'd1000);
    @(negedge clk);
    check_eq("to:busy", 32'(busy), 32'd0);
    check_eq("to:err_cnt", 32'(err_cnt), 32'(exp_err_cnt));

    // Reset in the middle of an unacknowledged write.
    ack_en = 1'b0;
    frm = '{8'hA5, 8'h01, 8'h30, 8'h00, 8'h01, 8'h55};
    foreach (frm[i]) send_byte(frm[i], 1);
    check_eq("mrst:mem_req_before", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    check_eq("mrst:mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("mrst:busy", 32'(busy), 32'd0);
    check_eq("mrst:cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("mrst:err_cnt", 32'(err_cnt), 32'd0);
    check_eq("mrst:mem_addr", 32'(bus.mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mrst:level_not_accepted", 32'(busy), 32'd0);
    bus.rx_valid = 1'b0;
    ack_en = 1'b1;
    exp_cpu_rst  = 1'b1;
    exp_run_addr = 16'h0000;
    exp_err_cnt  = 8'h00;
    repeat (2) @(negedge clk);
    frm = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h00, 8'hB8};
    run_frame("post_rst_run", 1);

    // err_cnt saturation with 300 bad-command frames.
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 1);
      send_byte(8'h09, 1);
      exp_err_cnt = sat8(exp_err_cnt);
    end
    repeat (3) @(negedge clk);
    check_eq("sat:err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    check_eq("sat:err_cnt_ff", 32'(err_cnt), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
